ucsbece154a_muldiv: RTL and testbench
=====================================

Name: ucsbece154a_muldiv

Overview:
- Parametrised multicycle multiply/divide unit that extends the integer ALU with MIPS mult/multu/div/divu and mthi/mtlo.
- Owns the HI/LO architectural registers.
- Sits beside the ALU in the multicycle datapath. The controller starts an operation, stalls on busy_o, and reads hi_o/lo_o for mfhi/mflo.
- Shift-add multiply and restoring divide, one result bit per cycle.

Parameters:
- WIDTH, 32, operand width and HI/LO register width (min 4).
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  operation request, sampled only in IDLE
- op_i  in  3  operation code (MDOp_* constants)
- a_i  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source)
- b_i  in  WIDTH  rt operand (multiplier / divisor)
- busy_o  out  1  high while an iterative operation is in progress
- done_o  out  1  one-cycle pulse when HI/LO reflect the finished operation
- divzero_o  out  1  one-cycle pulse, coincident with done_o, on divide by zero
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Op codes: MDOp_multu=0, MDOp_mult=1, MDOp_divu=2, MDOp_div=3, MDOp_mthi=4, MDOp_mtlo=5. Codes 6–7 are ignored: no state change, no done.
- Reset (async): state=IDLE, hi_o=lo_o=0, busy_o=done_o=divzero_o=0, counter=0. Reset during RUN aborts the operation with no partial write to HI/LO.
- FSM states:
  - IDLE: waits for start_i.
  - RUN: iterates.
  - FIN: registers results, pulses done.
- IDLE, start_i=1, mult*/div* with a nonzero divisor: latch the operand magnitudes (abs for signed ops) and the result signs; counter=WIDTH; go to RUN.
- RUN: one iteration per cycle, counter decrements. When counter reaches 1, go to FIN.
- FIN: write HI/LO with sign-corrected results; done_o=1 for exactly this cycle; return to IDLE.
- Latency: start sampled at edge 0 → done_o high in cycle WIDTH+1 (cycle 33 for WIDTH=32). busy_o is high from the cycle after the start edge through the FIN cycle inclusive.
- mthi/mtlo: write hi_o or lo_o from a_i at the start edge; done_o pulses in the next cycle; busy_o stays 0.
- Divide by zero (div/divu, b_i=0): HI/LO unchanged; done_o and divzero_o pulse in the next cycle; busy_o stays 0.
- Multiply result: {hi,lo} = 2*WIDTH-bit product. Signed mult negates the 2W product when the operand signs differ.
- Divide result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Signed overflow, -2^(W-1) / -1: lo=-2^(W-1) (two's complement wrap), hi=0. No flag.
- start_i while busy_o=1 or during FIN is ignored; it is not queued.
- Operand inputs need only be valid in the start cycle. The unit holds its own copies.
- HI/LO hold their value in every cycle except the write edge.

Decomposition:
- Shared header ucsbece154a_defines.vh gains:
  - the MDOp_* localparams;
  - MDState_idle / MDState_run / MDState_fin encodings.
- One natural sub-module: ucsbece154a_negcond (combinational, parametrised width). It computes a conditional two's complement negate and is reused for operand abs and result sign correction.
- Iteration datapath and FSM remain in the top module.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → done_o at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; busy_o high cycles 1–33.
- mult a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Then divu a=7, b=0 → divzero_o and done_o pulse at cycle 1, HI/LO unchanged.
- mthi a=0x12345678 then mtlo a=0x9ABCDEF0 → hi/lo updated on the start edges, each done pulse one cycle later, busy_o never asserted.
- Start a multu, pulse start_i with divu at cycle 10 → ignored; multu result correct at cycle 33. Assert reset at cycle 20 of a new mult → hi=lo=0, busy_o=0 immediately, no done_o.
- WIDTH=8 instance: mult a=0x80, b=0x80 → hi=0x40, lo=0x00, done at cycle 9. Randomised 1000-op run against a behavioural model.

Source files
------------

// File: rtl/ucsbece154a_muldiv_pkg.sv
// Operation codes, FSM encodings and op-class helpers shared by the
// multicycle multiply/divide unit.
package ucsbece154a_muldiv_pkg;

    localparam logic [2:0] MDOp_multu = 3'd0;
    localparam logic [2:0] MDOp_mult  = 3'd1;
    localparam logic [2:0] MDOp_divu  = 3'd2;
    localparam logic [2:0] MDOp_div   = 3'd3;
    localparam logic [2:0] MDOp_mthi  = 3'd4;
    localparam logic [2:0] MDOp_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        MDState_idle = 2'd0,
        MDState_run  = 2'd1,
        MDState_fin  = 2'd2
    } md_state_e;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MDOp_multu) || (op == MDOp_mult);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MDOp_divu) || (op == MDOp_div);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MDOp_mult) || (op == MDOp_div);
    endfunction

endpackage

// File: rtl/ucsbece154a_negcond.sv
// Conditional two's complement negate; used both to take operand magnitudes
// and to restore the sign of finished results.
module ucsbece154a_negcond #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? ((~a_i) + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/ucsbece154a_muldiv.sv
// Multicycle MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, one result bit per cycle.
module ucsbece154a_muldiv
    import ucsbece154a_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             divzero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] upper_q, upper_d, lower_q, lower_d, opnd_q, opnd_d;
    logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic             a_neg, b_neg, b_zero, launch;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] step_upper, step_lower;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_neg  = md_is_signed(op_i) & a_i[WIDTH-1];
    assign b_neg  = md_is_signed(op_i) & b_i[WIDTH-1];
    assign b_zero = (b_i == {WIDTH{1'b0}});
    assign launch = start_i && (md_is_mul(op_i) || (md_is_div(op_i) && !b_zero));

    ucsbece154a_negcond #(.W(WIDTH)) u_abs_a (.neg_i(a_neg), .a_i(a_i), .y_o(abs_a));
    ucsbece154a_negcond #(.W(WIDTH)) u_abs_b (.neg_i(b_neg), .a_i(b_i), .y_o(abs_b));

    // Multiply: {upper,lower} shifts right, adding the multiplicand on lower[0].
    // Divide: {upper,lower} shifts left, subtracting the divisor when it fits.
    assign mul_sum    = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift  = {upper_q, lower_q[WIDTH-1]};
    assign div_ge     = (div_shift >= {1'b0, opnd_q});
    assign step_upper = is_div_q ? (div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0])
                                 : mul_sum[WIDTH:1];
    assign step_lower = is_div_q ? {lower_q[WIDTH-2:0], div_ge}
                                 : {mul_sum[0], lower_q[WIDTH-1:1]};

    ucsbece154a_negcond #(.W(2*WIDTH)) u_fix_prod (.neg_i(neg_lo_q), .a_i({step_upper, step_lower}), .y_o(prod_fix));
    ucsbece154a_negcond #(.W(WIDTH))   u_fix_quo  (.neg_i(neg_lo_q), .a_i(step_lower), .y_o(quo_fix));
    ucsbece154a_negcond #(.W(WIDTH))   u_fix_rem  (.neg_i(neg_hi_q), .a_i(step_upper), .y_o(rem_fix));

    // State, iteration and architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MDState_idle;
            cnt_q    <= {CW{1'b0}};
            upper_q  <= {WIDTH{1'b0}};
            lower_q  <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            upper_q  <= upper_d;
            lower_q  <= lower_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDState_idle: begin
                if (launch) state_d = MDState_run;
                else        state_d = MDState_idle;
            end
            MDState_run: begin
                if (cnt_q == CNT_ONE) state_d = MDState_fin;
                else                  state_d = MDState_run;
            end
            MDState_fin: state_d = MDState_idle;
            default:     state_d = MDState_idle;
        endcase
    end

    // Datapath and output logic. Results are committed on the edge entering
    // FIN so HI/LO already hold them while done_o is high.
    always_comb begin
        cnt_d    = cnt_q;
        upper_d  = upper_q;
        lower_d  = lower_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        busy_d   = (state_d == MDState_run) || (state_d == MDState_fin);
        case (state_q)
            MDState_idle: begin
                if (start_i) begin
                    case (op_i)
                        MDOp_multu, MDOp_mult: begin
                            opnd_d   = abs_a;
                            lower_d  = abs_b;
                            upper_d  = {WIDTH{1'b0}};
                            is_div_d = 1'b0;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = 1'b0;
                            cnt_d    = CNT_INIT;
                        end
                        MDOp_divu, MDOp_div: begin
                            if (b_zero) begin
                                done_d = 1'b1;
                                dz_d   = 1'b1;
                            end else begin
                                opnd_d   = abs_b;
                                lower_d  = abs_a;
                                upper_d  = {WIDTH{1'b0}};
                                is_div_d = 1'b1;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = a_neg;
                                cnt_d    = CNT_INIT;
                            end
                        end
                        MDOp_mthi: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        MDOp_mtlo: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        default: done_d = 1'b0;
                    endcase
                end else begin
                    done_d = 1'b0;
                end
            end
            MDState_run: begin
                upper_d = step_upper;
                lower_d = step_lower;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            MDState_fin: done_d = 1'b0;
            default:     done_d = 1'b0;
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign divzero_o = dz_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_ucsbece154a_muldiv.sv
// Directed-vector, corner-sequence and model-compared random bench for the
// multiply/divide unit at WIDTH=32 and WIDTH=8.
module tb_ucsbece154a_muldiv;
    import ucsbece154a_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, busy32, done32, dz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, busy8, done8, dz8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ucsbece154a_muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
        .busy_o(busy32), .done_o(done32), .divzero_o(dz32), .hi_o(hi32), .lo_o(lo32)
    );

    ucsbece154a_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .divzero_o(dz8), .hi_o(hi8), .lo_o(lo8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t vec [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the selected instance and watch it until done or limit.
    task automatic run_op(input logic w8, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int limit, output logic got_done, output int lat, output logic dz_at,
                          output int busy_cnt, output logic dz_stray,
                          output logic [31:0] rhi, output logic [31:0] rlo);
        logic d, z, bz;
        if (w8) begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
        end else begin
            op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        end
        tick();
        start8 = 1'b0; start32 = 1'b0;
        a32 = ~x; b32 = ~y; a8 = ~x[7:0]; b8 = ~y[7:0];
        got_done = 1'b0; lat = 0; dz_at = 1'b0; busy_cnt = 0; dz_stray = 1'b0;
        for (int c = 1; c <= limit && !got_done; c++) begin
            d  = w8 ? done8 : done32;
            z  = w8 ? dz8   : dz32;
            bz = w8 ? busy8 : busy32;
            if (bz) busy_cnt++;
            if (d) begin
                got_done = 1'b1; lat = c; dz_at = z;
            end else if (z) begin
                dz_stray = 1'b1;
            end
            tick();
        end
        rhi = w8 ? {24'd0, hi8} : hi32;
        rlo = w8 ? {24'd0, lo8} : lo32;
    endtask

    // Behavioural reference using native wide arithmetic.
    task automatic model(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] h, inout logic [31:0] l, output logic z);
        logic [63:0]        mask, ux, uy, up;
        logic signed [63:0] sx, sy, sp, sr;
        mask = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & mask;
        uy = {32'd0, y} & mask;
        sx = x[w-1] ? (ux | ~mask) : ux;
        sy = y[w-1] ? (uy | ~mask) : uy;
        z  = 1'b0;
        case (o)
            MDOp_multu: begin
                up = ux * uy;
                h = 32'((up >> w) & mask); l = 32'(up & mask);
            end
            MDOp_mult: begin
                sp = sx * sy; up = sp;
                h = 32'((up >> w) & mask); l = 32'(up & mask);
            end
            MDOp_divu: begin
                if (uy == 64'd0) z = 1'b1;
                else begin l = 32'(ux / uy); h = 32'(ux % uy); end
            end
            MDOp_div: begin
                if (uy == 64'd0) z = 1'b1;
                else begin
                    sp = sx / sy; sr = sx % sy;
                    up = sp; l = 32'(up & mask);
                    up = sr; h = 32'(up & mask);
                end
            end
            MDOp_mthi: h = 32'(ux);
            MDOp_mtlo: l = 32'(ux);
            default: z = 1'b0;
        endcase
    endtask

    initial begin
        logic        gd, dzq, dzs, ez, dzany;
        int          lat, bc, dcyc, extra, ndone, w, nops, elat;
        logic [31:0] rh, rl, mh, ml, x, y, mask;
        logic [2:0]  o;

        vec[0]  = '{MDOp_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33};
        vec[1]  = '{MDOp_mult,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 33};
        vec[2]  = '{MDOp_div,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
        vec[3]  = '{MDOp_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 33};
        vec[4]  = '{MDOp_divu,  32'h00000007, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 1, 0};
        vec[5]  = '{MDOp_mthi,  32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 1'b0, 1, 0};
        vec[6]  = '{MDOp_mtlo,  32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, 0};
        vec[7]  = '{MDOp_divu,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33, 33};
        vec[8]  = '{MDOp_mult,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 33, 33};
        vec[9]  = '{MDOp_multu, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33, 33};
        vec[10] = '{MDOp_div,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 33};
        vec[11] = '{MDOp_div,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 33, 33};
        vec[12] = '{3'd6,       32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000003, 1'b0, 0, 0};
        vec[13] = '{MDOp_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 33};

        reset = 1'b1;
        start32 = 1'b0; op32 = 3'd0; a32 = 32'd0; b32 = 32'd0;
        start8  = 1'b0; op8  = 3'd0; a8  = 8'd0;  b8  = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset hi", hi32, 32'd0);
        check("reset lo", lo32, 32'd0);
        check("reset busy/done/dz", {29'd0, busy32, done32, dz32}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(1'b0, vec[i].op, vec[i].a, vec[i].b, 40, gd, lat, dzq, bc, dzs, rh, rl);
            if (vec[i].lat == 0) begin
                check($sformatf("vec%0d no_done", i), {31'd0, gd}, 32'd0);
            end else begin
                check($sformatf("vec%0d latency", i), lat, vec[i].lat);
                check($sformatf("vec%0d divzero", i), {31'd0, dzq}, {31'd0, vec[i].dz});
            end
            check($sformatf("vec%0d busy_cycles", i), bc, vec[i].bsy);
            check($sformatf("vec%0d stray_dz", i), {31'd0, dzs}, 32'd0);
            check($sformatf("vec%0d hi", i), rh, vec[i].hi);
            check($sformatf("vec%0d lo", i), rl, vec[i].lo);
        end

        // Starts while busy and during FIN must be dropped.
        op32 = MDOp_multu; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        tick();
        dcyc = 0; extra = 0; dzany = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            start32 = 1'b0;
            if (done32 && dcyc == 0) dcyc = c;
            else if (done32) extra++;
            if (dz32) dzany = 1'b1;
            if (c == 10) begin op32 = MDOp_divu; a32 = 32'd100; b32 = 32'd0; start32 = 1'b1; end
            if (c == dcyc) begin op32 = MDOp_mthi; a32 = 32'hDEADBEEF; start32 = 1'b1; end
            tick();
        end
        check("ignore done_cycle", dcyc, 33);
        check("ignore no_dz", {31'd0, dzany}, 32'd0);
        check("ignore no_extra_done", extra, 0);
        check("ignore hi", hi32, 32'd0);
        check("ignore lo", lo32, 32'd15);

        // Reset in the middle of an iterative op.
        op32 = MDOp_mult; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        check("midreset busy_before", {31'd0, busy32}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy32}, 32'd0);
        check("midreset hi", hi32, 32'd0);
        check("midreset lo", lo32, 32'd0);
        tick(); tick();
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32) ndone++;
            tick();
        end
        check("midreset no_done", ndone, 0);
        check("midreset lo_after", lo32, 32'd0);

        // Narrow instance corners.
        run_op(1'b1, MDOp_mult, 32'h80, 32'h80, 20, gd, lat, dzq, bc, dzs, rh, rl);
        check("w8 mult latency", lat, 9);
        check("w8 mult hi", rh, 32'h40);
        check("w8 mult lo", rl, 32'h00);
        run_op(1'b1, MDOp_divu, 32'hFF, 32'h10, 20, gd, lat, dzq, bc, dzs, rh, rl);
        check("w8 divu hi", rh, 32'h0F);
        check("w8 divu lo", rl, 32'h0F);
        run_op(1'b1, MDOp_div, 32'h80, 32'hFF, 20, gd, lat, dzq, bc, dzs, rh, rl);
        check("w8 div_ovf hi", rh, 32'h00);
        check("w8 div_ovf lo", rl, 32'h80);

        // Random ops against the reference model on both widths.
        for (int wi = 0; wi < 2; wi++) begin
            w    = (wi == 0) ? 32 : 8;
            nops = (wi == 0) ? 200 : 1000;
            mask = (wi == 0) ? 32'hFFFFFFFF : 32'h000000FF;
            mh   = (wi == 0) ? hi32 : 32'h00;
            ml   = (wi == 0) ? lo32 : 32'h80;
            if (wi == 0) begin
                mh = 32'd0; ml = 32'd0;
            end
            for (int i = 0; i < nops; i++) begin
                o = 3'($urandom_range(0, 5));
                x = $urandom & mask;
                y = $urandom & mask;
                case ($urandom_range(0, 7))
                    0: y = 32'd0;
                    1: y = y & 32'h0000000F;
                    2: begin x = 32'd1 << (w - 1); y = mask; end
                    default: y = y;
                endcase
                model(w, o, x, y, mh, ml, ez);
                elat = (o <= MDOp_div && !ez) ? (w + 1) : 1;
                run_op(wi == 1, o, x, y, 40, gd, lat, dzq, bc, dzs, rh, rl);
                check($sformatf("rand%0d_%0d latency", w, i), lat, elat);
                check($sformatf("rand%0d_%0d divzero", w, i), {31'd0, dzq}, {31'd0, ez});
                check($sformatf("rand%0d_%0d hi", w, i), rh, mh);
                check($sformatf("rand%0d_%0d lo", w, i), rl, ml);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
